// File: rtl/al2_pkg.sv
`default_nettype none
// ============================================================================
// Module      : al2_pkg
// Description : Shared constants, FSM state type and the al2 function for the
//               onset enumerator and its evaluator.
// Revision    : 1.0
// ============================================================================
package al2_pkg;

   localparam int AL2_N_IN  = 11;
   localparam int AL2_CNT_W = 12;

   localparam logic [AL2_N_IN-1:0] AL2_LAST_IDX = 11'h7FF;

   // Sizes of the ON-set and OFF-set of f over all 2^11 vectors.
   localparam int AL2_ON_CNT  = 250;
   localparam int AL2_OFF_CNT = 1798;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SCAN = 2'd1,
      ST_HOLD = 2'd2,
      ST_DONE = 2'd3
   } al2_state_t;

   function automatic logic al2_f(input logic [AL2_N_IN-1:0] x);
      logic c_term_a;
      logic c_term_b;
      c_term_a = x[6] & ~x[7] & ~x[8] & ~x[9] & x[10];
      c_term_b = ~x[0] & ~x[5] & (x[1] ^ x[2]) & (x[3] | x[4]);
      return c_term_a | c_term_b;
   endfunction

endpackage : al2_pkg
`default_nettype wire

// File: rtl/al2_eval.sv
`default_nettype none
// ============================================================================
// Module      : al2_eval
// Description : Purely combinational evaluation of the al2 function.
// Revision    : 1.0
// ============================================================================
module al2_eval
   import al2_pkg::*;
(
   input  logic [AL2_N_IN-1:0] x,
   output logic                f
);

   assign f = al2_f(x);

endmodule : al2_eval
`default_nettype wire

// File: rtl/al2_onset_enumerator.sv
`default_nettype none
// ============================================================================
// Module      : al2_onset_enumerator
// Description : Sweeps every input vector of al2 in ascending order and streams
//               those whose value equals the requested polarity.
// Revision    : 1.0
// ============================================================================
module al2_onset_enumerator
   import al2_pkg::*;
#(
   parameter int N_IN  = AL2_N_IN,
   parameter int CNT_W = AL2_CNT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             polarity,
   output logic             busy,
   output logic             done,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [N_IN-1:0]  m_data,
   output logic [CNT_W-1:0] count
);

   al2_state_t        r_state;
   logic [N_IN-1:0]   r_idx;
   logic              r_pol;
   logic              r_busy;
   logic              r_done;
   logic              r_valid;
   logic [N_IN-1:0]   r_data;
   logic [CNT_W-1:0]  r_count;
   logic              w_f;
   logic              w_last;

   al2_eval u_eval (
      .x (r_idx),
      .f (w_f)
   );

   // Termination is an explicit compare so the sweep never relies on wrap.
   assign w_last = (r_idx == AL2_LAST_IDX);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_idx   <= '0;
         r_pol   <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_valid <= 1'b0;
         r_data  <= '0;
         r_count <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_pol   <= polarity;
                  r_idx   <= '0;
                  r_count <= '0;
                  r_busy  <= 1'b1;
                  r_state <= ST_SCAN;
               end
            end
            ST_SCAN: begin
               if (w_f == r_pol) begin
                  r_data  <= r_idx;
                  r_valid <= 1'b1;
                  r_state <= ST_HOLD;
               end else if (w_last) begin
                  r_done  <= 1'b1;
                  r_state <= ST_DONE;
               end else begin
                  r_idx <= r_idx + 1'b1;
               end
            end
            ST_HOLD: begin
               if (m_ready) begin
                  r_count <= r_count + 1'b1;
                  r_valid <= 1'b0;
                  if (w_last) begin
                     r_done  <= 1'b1;
                     r_state <= ST_DONE;
                  end else begin
                     r_idx   <= r_idx + 1'b1;
                     r_state <= ST_SCAN;
                  end
               end
            end
            ST_DONE: begin
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign busy    = r_busy;
   assign done    = r_done;
   assign m_valid = r_valid;
   assign m_data  = r_data;
   assign count   = r_count;

endmodule : al2_onset_enumerator
`default_nettype wire
